// File: rtl/pll_reset_seq.sv
// ============================================================================
// pll_reset_seq : PLL reset / lock-qualification sequencer on the reference clock
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module pll_reset_seq #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 65536,
  parameter int STABLE_CYCLES = 1024,
  parameter int CNT_W         = 8
) (
  input  logic             refclk,
  input  logic             rst_n,
  input  logic             locked,
  input  logic             soft_req,
  output logic             pll_rst,
  output logic             sys_reset,
  output logic             ready,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] loss_count,
  output logic [CNT_W-1:0] timeout_count
);

  localparam int MAX_AB  = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_CYC = (MAX_AB > STABLE_CYCLES) ? MAX_AB : STABLE_CYCLES;
  localparam int CYC_W   = (MAX_CYC < 2) ? 1 : $clog2(MAX_CYC);

  localparam logic [CYC_W-1:0] RST_LAST     = CYC_W'(RST_CYCLES - 1);
  localparam logic [CYC_W-1:0] TIMEOUT_LAST = CYC_W'(LOCK_TIMEOUT - 1);
  // The WAIT_LOCK->STABLE edge already consumed one locked sample.
  localparam logic [CYC_W-1:0] STABLE_LAST  =
      CYC_W'((STABLE_CYCLES >= 2) ? (STABLE_CYCLES - 2) : 0);

  typedef enum logic [1:0] {
    ST_PLLRST    = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_STABLE    = 2'd2,
    ST_RUN       = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CYC_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   loss_q, loss_d;
  logic [CNT_W-1:0]   tmo_q, tmo_d;
  logic               lock_meta_q;
  logic               locked_s_q;
  logic               pll_rst_q, pll_rst_d;
  logic               sys_reset_q, sys_reset_d;
  logic               ready_q, ready_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    sat_inc = (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  always_comb begin
    state_d = state_q;
    loss_d  = loss_q;
    tmo_d   = tmo_q;

    if (soft_req) begin
      state_d = ST_PLLRST;
    end else begin
      case (state_q)
        ST_PLLRST: begin
          if (cnt_q == RST_LAST) state_d = ST_WAIT_LOCK;
        end
        ST_WAIT_LOCK: begin
          if (locked_s_q) begin
            state_d = ST_STABLE;
          end else if (cnt_q == TIMEOUT_LAST) begin
            state_d = ST_PLLRST;
            tmo_d   = sat_inc(tmo_q);
          end
        end
        ST_STABLE: begin
          if (!locked_s_q)                state_d = ST_WAIT_LOCK;
          else if (cnt_q == STABLE_LAST)  state_d = ST_RUN;
        end
        ST_RUN: begin
          if (!locked_s_q) begin
            state_d = ST_PLLRST;
            loss_d  = sat_inc(loss_q);
          end
        end
        default: state_d = ST_PLLRST;
      endcase
    end

    // Counter only measures dwell time, so it restarts on any entry and idles in RUN.
    if (soft_req || (state_d != state_q) || (state_q == ST_RUN)) cnt_d = '0;
    else                                                          cnt_d = cnt_q + 1'b1;

    pll_rst_d   = (state_d == ST_PLLRST);
    sys_reset_d = (state_d != ST_RUN);
    ready_d     = (state_d == ST_RUN);
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_PLLRST;
      cnt_q       <= '0;
      loss_q      <= '0;
      tmo_q       <= '0;
      lock_meta_q <= 1'b0;
      locked_s_q  <= 1'b0;
      pll_rst_q   <= 1'b1;
      sys_reset_q <= 1'b1;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      loss_q      <= loss_d;
      tmo_q       <= tmo_d;
      lock_meta_q <= locked;
      locked_s_q  <= lock_meta_q;
      pll_rst_q   <= pll_rst_d;
      sys_reset_q <= sys_reset_d;
      ready_q     <= ready_d;
    end
  end

  assign pll_rst       = pll_rst_q;
  assign sys_reset     = sys_reset_q;
  assign ready         = ready_q;
  assign state         = state_q;
  assign loss_count    = loss_q;
  assign timeout_count = tmo_q;

endmodule

`default_nettype wire

// File: tb/tb_pll_reset_seq.sv
// ============================================================================
// tb_pll_reset_seq : directed, table-driven bench for pll_reset_seq
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pll_reset_seq;

  localparam int CNT_W = 8;

  logic             refclk = 1'b0;
  logic             rst_n;
  logic             locked;
  logic             soft_req;
  logic             pll_rst;
  logic             sys_reset;
  logic             ready;
  logic [1:0]       state;
  logic [CNT_W-1:0] loss_count;
  logic [CNT_W-1:0] timeout_count;

  pll_reset_seq #(
    .RST_CYCLES   (4),
    .LOCK_TIMEOUT (32),
    .STABLE_CYCLES(8),
    .CNT_W        (CNT_W)
  ) dut (
    .refclk       (refclk),
    .rst_n        (rst_n),
    .locked       (locked),
    .soft_req     (soft_req),
    .pll_rst      (pll_rst),
    .sys_reset    (sys_reset),
    .ready        (ready),
    .state        (state),
    .loss_count   (loss_count),
    .timeout_count(timeout_count)
  );

  always #10 refclk = ~refclk;

  // One record = n consecutive cycles with fixed inputs and fixed expected outputs.
  typedef struct {
    int n;
    int lk;
    int sr;
    int st;
    int loss;
    int to;
  } seg_t;

  seg_t seq [38];
  int   vectors = 0;
  int   miscompares = 0;
  int   edge_n = 0;

  task automatic check(input string name, input int idx, input int st,
                       input int loss, input int to);
    logic       e_pll, e_sys, e_rdy;
    logic [7:0] e_loss, e_to;
    e_pll  = (st == 0);
    e_sys  = (st != 3);
    e_rdy  = (st == 3);
    e_loss = loss[7:0];
    e_to   = to[7:0];
    vectors++;
    if (int'(state) != st || pll_rst !== e_pll || sys_reset !== e_sys ||
        ready !== e_rdy || loss_count !== e_loss || timeout_count !== e_to) begin
      miscompares++;
      $display("FAIL %s[%0d] edge %0d: got state=%0d pll_rst=%b sys_reset=%b ready=%b loss=%0d timeout=%0d, expected state=%0d pll_rst=%b sys_reset=%b ready=%b loss=%0d timeout=%0d",
               name, idx, edge_n, state, pll_rst, sys_reset, ready, loss_count,
               timeout_count, st, e_pll, e_sys, e_rdy, e_loss, e_to);
    end
  endtask

  task automatic run_segs(input int first, input int last);
    for (int s = first; s <= last; s++) begin
      for (int c = 0; c < seq[s].n; c++) begin
        locked   = (seq[s].lk != 0);
        soft_req = (seq[s].sr != 0);
        @(posedge refclk);
        @(negedge refclk);
        edge_n++;
        check("seg", s, seq[s].st, seq[s].loss, seq[s].to);
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge refclk);
      @(negedge refclk);
      edge_n++;
    end
  endtask

  initial begin
    //            n  lk sr st loss to        edges after rst_n release
    seq[0]  = '{ 3, 0, 0, 0, 0, 0};        // 1-3   PLL reset pulse
    seq[1]  = '{ 7, 0, 0, 1, 0, 0};        // 4-10  pll_rst falls at edge 4
    seq[2]  = '{ 2, 1, 0, 1, 0, 0};        // 11-12 locked raised, still syncing
    seq[3]  = '{ 7, 1, 0, 2, 0, 0};        // 13-19 qualification
    seq[4]  = '{ 3, 1, 0, 3, 0, 0};        // 20-22 released at edge 20
    seq[5]  = '{ 1, 0, 0, 3, 0, 0};        // 23    one-cycle lock drop
    seq[6]  = '{ 1, 1, 0, 3, 0, 0};        // 24
    seq[7]  = '{ 4, 1, 0, 0, 1, 0};        // 25-28 loss seen 3rd edge
    seq[8]  = '{ 1, 1, 0, 1, 1, 0};        // 29
    seq[9]  = '{ 7, 1, 0, 2, 1, 0};        // 30-36
    seq[10] = '{ 3, 1, 0, 3, 1, 0};        // 37-39
    seq[11] = '{ 2, 0, 0, 3, 1, 0};        // 40-41 locked_s falls into edge 42
    seq[12] = '{ 1, 0, 1, 0, 1, 0};        // 42    soft_req with loss: no count
    seq[13] = '{ 3, 0, 0, 0, 1, 0};        // 43-45
    seq[14] = '{ 2, 0, 0, 1, 1, 0};        // 46-47
    seq[15] = '{ 2, 1, 0, 1, 1, 0};        // 48-49 chatter: 5 high cycles
    seq[16] = '{ 3, 1, 0, 2, 1, 0};        // 50-52
    seq[17] = '{ 1, 0, 0, 2, 1, 0};        // 53    one low cycle
    seq[18] = '{ 1, 1, 0, 2, 1, 0};        // 54
    seq[19] = '{ 1, 1, 0, 1, 1, 0};        // 55    back to WAIT_LOCK
    seq[20] = '{ 7, 1, 0, 2, 1, 0};        // 56-62
    seq[21] = '{ 3, 1, 0, 3, 1, 0};        // 63-65 release 8 after 2nd rise
    seq[22] = '{ 2, 0, 0, 3, 1, 0};        // 66-67 lock lost for good
    seq[23] = '{ 4, 0, 0, 0, 2, 0};        // 68-71
    seq[24] = '{32, 0, 0, 1, 2, 0};        // 72-103
    seq[25] = '{ 4, 0, 0, 0, 2, 1};        // 104-107 timeout 1
    seq[26] = '{32, 0, 0, 1, 2, 1};        // 108-139
    seq[27] = '{ 4, 0, 0, 0, 2, 2};        // 140-143 timeout 2
    seq[28] = '{32, 0, 0, 1, 2, 2};        // 144-175
    seq[29] = '{ 4, 0, 0, 0, 2, 3};        // 176-179 timeout 3
    seq[30] = '{32, 0, 0, 1, 2, 3};        // 180-211
    seq[31] = '{ 1, 0, 1, 0, 2, 3};        // 212   soft_req with timeout: no count
    seq[32] = '{ 3, 0, 0, 0, 2, 3};        // 213-215
    seq[33] = '{ 2, 0, 0, 1, 2, 3};        // 216-217
    seq[34] = '{ 3, 1, 0, 0, 0, 0};        // after mid-STABLE reset: 1-3
    seq[35] = '{ 1, 1, 0, 1, 0, 0};        // 4
    seq[36] = '{ 7, 1, 0, 2, 0, 0};        // 5-11
    seq[37] = '{ 2, 1, 0, 3, 0, 0};        // 12-13

    rst_n    = 1'b0;
    locked   = 1'b0;
    soft_req = 1'b0;
    repeat (3) @(negedge refclk);
    check("reset", 0, 0, 0, 0);

    rst_n  = 1'b1;
    edge_n = 0;
    run_segs(0, 33);

    // Timeouts every 36 edges from edge 248; the 251st after that saturates.
    idle(9283 - edge_n);
    check("sat_pre", 0, 1, 2, 254);
    idle(1);
    check("sat_hit", 0, 0, 2, 255);
    idle(300 * 36);
    check("sat_hold", 0, 0, 2, 255);

    locked = 1'b1;
    idle(8);
    check("pre_reset_stable", 0, 2, 2, 255);

    #3;
    rst_n = 1'b0;
    #1;
    check("async_reset", 0, 0, 0, 0);
    @(negedge refclk);
    check("reset_held", 0, 0, 0, 0);

    rst_n  = 1'b1;
    edge_n = 0;
    run_segs(34, 37);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pll_reset_seq.md
Name: pll_reset_seq

Overview:
- Other end of the PLL rst/locked interface: drives the PLL reset and consumes its locked flag.
- Sequences power-up: PLL reset pulse, wait for lock, lock-stability qualification, then release of the system reset for logic on outclk_0/outclk_1.
- Monitors lock continuously.
  - On loss of lock, re-asserts system reset immediately and restarts the PLL.
  - On lock timeout, restarts the PLL.
- Runs on the free-running 50 MHz reference clock, never on a PLL output.

Parameters:
- RST_CYCLES, 16: refclk cycles pll_rst is held high per reset pulse (≥1).
- LOCK_TIMEOUT, 65536: refclk cycles to wait for lock before re-pulsing the PLL reset (≥1).
- STABLE_CYCLES, 1024: consecutive synchronized-locked cycles required before system reset release (≥1).
- CNT_W, 8: width of the saturating event counters.

Ports:
- refclk, input, 1: free-running reference clock, 50 MHz.
- rst_n, input, 1: asynchronous active-low reset.
- locked, input, 1: PLL lock flag; asynchronous to refclk.
- soft_req, input, 1: synchronous single-cycle request to restart the PLL and the system.
- pll_rst, output, 1: active-high reset to the PLL.
- sys_reset, output, 1: active-high reset to downstream logic; registered.
- ready, output, 1: high only in RUN.
- state, output, 2: 0=PLLRST, 1=WAIT_LOCK, 2=STABLE, 3=RUN.
- loss_count, output, CNT_W: lock losses seen in RUN; saturating.
- timeout_count, output, CNT_W: lock timeouts; saturating.

Behaviour:
- **Reset (rst_n low, asynchronous):**
  - Outputs: state=PLLRST, pll_rst=1, sys_reset=1, ready=0, loss_count=0, timeout_count=0.
  - Internals: cycle counter=0, sync flops=0.
- **locked synchronizer:** 2-flop synchronizer to locked_s; 2-cycle latency. Only locked_s is used.
- **One shared cycle counter:** cleared on every state change; sized for max(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES).
- **PLLRST:**
  - pll_rst=1, sys_reset=1.
  - After RST_CYCLES cycles in the state, go to WAIT_LOCK; pll_rst is 0 from that edge.
  - With rst_n released before edge 1, pll_rst falls at rising edge RST_CYCLES.
- **WAIT_LOCK:**
  - pll_rst=0, sys_reset=1.
  - locked_s=1: go to STABLE.
  - Counter reaches LOCK_TIMEOUT without lock: go to PLLRST and increment timeout_count.
- **STABLE:**
  - sys_reset=1.
  - locked_s=0: go to WAIT_LOCK. The counter restarts there and no count is incremented.
  - STABLE_CYCLES consecutive cycles with locked_s=1: go to RUN. sys_reset=0 and ready=1 from that edge.
- **RUN:**
  - sys_reset=0, ready=1.
  - locked_s=0: next edge sets sys_reset=1, ready=0, state=PLLRST, and increments loss_count.
  - sys_reset assertion latency from a raw locked fall is ≤3 refclk edges.
- **soft_req:** in any state, next edge goes to PLLRST with sys_reset=1 and the counter cleared. No counter is incremented.
- **Simultaneous events:**
  - soft_req wins over every other transition.
  - soft_req together with lock loss in RUN does not increment loss_count.
  - soft_req together with timeout does not increment timeout_count.
- **Counters:** saturate at 2^CNT_W−1; they never wrap. They clear only on rst_n.
- **Glitch rules:**
  - sys_reset and pll_rst are direct flop outputs, so they are glitch-free.
  - sys_reset never deasserts outside the STABLE→RUN transition.
- **rst_n mid-operation:** full return to reset values regardless of state; the sequence restarts from PLLRST.

Test Plan:
All scenarios use RST_CYCLES=4, LOCK_TIMEOUT=32, STABLE_CYCLES=8.
- **Power-up with clean lock:**
  - Stimulus: release rst_n; raise locked at edge 10 and hold it.
  - Required: pll_rst falls at edge 4; locked_s high at edge 12; sys_reset falls and ready rises at edge 20; both counts 0.
- **Lock never arrives:**
  - Stimulus: locked held 0.
  - Required: pll_rst re-pulses high for 4 cycles every 36 cycles; timeout_count=1, 2, 3…
  - Saturation: force 300 timeouts; timeout_count stays at 255.
- **Lock chatter in STABLE:**
  - Stimulus: locked high for 5 cycles, low for 1, then steady high.
  - Required: no sys_reset release after the first 5 high cycles; release occurs 8 cycles after the second locked_s rise; no counts incremented.
- **Loss in RUN:**
  - Stimulus: in RUN, drop locked for 1 cycle.
  - Required: sys_reset=1 within 3 edges; state=PLLRST; loss_count=1; full resequence follows.
- **soft_req during RUN coinciding with locked_s fall:**
  - Required: state goes to PLLRST next edge; loss_count unchanged; pll_rst high for 4 cycles.
- **rst_n asserted mid-STABLE:**
  - Required: all outputs return to reset values immediately; counts return to 0.
